// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// MODE 0 passes the channel picked by sel; MODE 1 arbitrates round-robin from ptr.
module stream_mux_rr #(
  parameter int W    = 3,
  parameter int N    = 4,
  parameter int MODE = 0,
  localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_chan
);

  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_chan_q, out_chan_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load_ok;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;

  // Grant selection. Reset suppresses every grant so in_ready stays low while rst is high.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    load_ok   = !out_valid_q || out_ready;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (!rst && en && load_ok) begin
      if (MODE == 0) begin
        // A sel value >= N matches no channel, so no grant results.
        for (int i = 0; i < N; i++) begin
          if (sel == SW'(i) && in_valid[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SW'(i);
          end
        end
      end else begin
        // Search offsets 0..N-1 from ptr; the first valid channel found wins.
        for (int k = 0; k < N; k++) begin
          for (int i = 0; i < N; i++) begin
            if (!gnt_valid && in_valid[i] && ((int'(ptr_q) + k) % N) == i) begin
              gnt_valid = 1'b1;
              gnt_idx   = SW'(i);
            end
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_valid && gnt_idx == SW'(i)) begin
        in_ready[i] = 1'b1;
        gnt_data    = in_data[i*W +: W];
      end
    end
  end

  // Output stage: load on grant (covers drain-and-refill in one cycle), clear on a bare drain,
  // otherwise hold so a stalled beat stays stable.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (gnt_valid) begin
      out_data_d  = gnt_data;
      out_valid_d = 1'b1;
      out_chan_d  = gnt_idx;
      if (MODE == 1) begin
        ptr_d = SW'((int'(gnt_idx) + 1) % N);
      end
    end else if (out_valid_q && out_ready) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_chan_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule
